// File: rtl/calc_arbiter_if.sv
// Bundle of requester, shared-calculator and response signals around calc_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface calc_arbiter_if;
    logic        req0_valid;
    logic [17:0] req0_din;
    logic        req0_ready;
    logic        req1_valid;
    logic [17:0] req1_din;
    logic        req1_ready;
    logic [17:0] calc_din;
    logic [15:0] calc_result;
    logic        calc_neg;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_neg;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    modport slave (
        input  req0_valid, req0_din,
        output req0_ready,
        input  req1_valid, req1_din,
        output req1_ready,
        output calc_din,
        input  calc_result, calc_neg,
        output rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_din,
        input  req0_ready,
        output req1_valid, req1_din,
        input  req1_ready,
        input  calc_din,
        output calc_result, calc_neg,
        input  rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one fixed-latency calculator between two requesters.
// One operation in flight; illegal opcodes are answered directly with an error response.
module calc_arbiter #(
    parameter int unsigned CALC_LAT = 2,
    parameter logic [17:0] IDLE_DIN = 18'h00000
) (
    input  logic          clk,
    input  logic          reset,
    calc_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(CALC_LAT);

    state_t      state;
    logic [3:0]  cnt;
    logic        last;
    logic        gnt_any;
    logic        gnt_id;
    logic [17:0] gnt_din;

    // Ready is only offered in IDLE and is masked while reset is held low.
    always_comb begin
        gnt_any        = 1'b0;
        gnt_id         = 1'b0;
        gnt_din        = bus.req0_din;
        gnt_any        = (state == IDLE) && reset && (bus.req0_valid || bus.req1_valid);
        gnt_id         = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
        gnt_din        = gnt_id ? bus.req1_din : bus.req0_din;
        bus.req0_ready = gnt_any && !gnt_id;
        bus.req1_ready = gnt_any && gnt_id;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 1'b1;
            bus.calc_din   <= IDLE_DIN;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_neg    <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        bus.rsp_id <= gnt_id;
                        bus.busy   <= 1'b1;
                        if (gnt_din[17:16] == 2'b11) begin
                            // Calculator is bypassed, so calc_din keeps the last legal word.
                            bus.rsp_result <= '0;
                            bus.rsp_neg    <= 1'b0;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end else begin
                            bus.calc_din <= gnt_din;
                            cnt          <= CNT_INIT;
                            state        <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        bus.rsp_result <= bus.calc_result;
                        bus.rsp_neg    <= bus.calc_neg;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        last          <= bus.rsp_id;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a latency-accurate calculator model.
module tb_calc_arbiter;
    localparam int unsigned LAT  = 3;
    localparam logic [17:0] IDIN = 18'h15A5A;
    localparam logic [17:0] D0   = 18'b00_11000010_11110110;
    localparam logic [17:0] D1   = 18'b01_00110110_10011011;
    localparam logic [17:0] D2   = 18'b10_10000110_01011001;
    localparam logic [17:0] DI   = 18'b11_00000001_00000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    calc_arbiter_if bus ();

    calc_arbiter #(.CALC_LAT(LAT), .IDLE_DIN(IDIN)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [16:0] calc(input logic [17:0] d);
        logic [15:0] a;
        logic [15:0] b;
        a = {8'h00, d[15:8]};
        b = {8'h00, d[7:0]};
        case (d[17:16])
            2'b00:   return {1'b0, a + b};
            2'b01:   return (a >= b) ? {1'b0, a - b} : {1'b1, b - a};
            2'b10:   return {1'b0, a * b};
            default: return '0;
        endcase
    endfunction

    // Result is only meaningful LAT edges after calc_din changes; garbage before that.
    logic [17:0] prev_din;
    int unsigned age = 0;
    always @(negedge clk) begin
        if (bus.calc_din !== prev_din) age = 0;
        else if (age < 100) age++;
        prev_din = bus.calc_din;
        if (age >= LAT - 1) {bus.calc_neg, bus.calc_result} = calc(bus.calc_din);
        else                {bus.calc_neg, bus.calc_result} = {1'b1, 16'hDEAD};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int gid[4];
    int gcyc[4];
    int ng;

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_din   = D0;
        bus.req1_valid = 1'b0;
        bus.req1_din   = '0;
        bus.rsp_ready  = 1'b0;

        // Reset values; ready masked while reset low even with a valid request.
        cyc(2);
        chk("rst_ready0", bus.req0_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_calc_din", bus.calc_din, IDIN);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_data", {bus.rsp_result, bus.rsp_neg, bus.rsp_err}, 18'h0);
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        cyc(1);

        // Single add from requester 0.
        bus.req0_valid = 1'b1;
        bus.req0_din   = D0;
        #1;
        chk("a_ready0", bus.req0_ready, 1'b1);
        chk("a_ready1", bus.req1_ready, 1'b0);
        cyc(1);
        bus.req0_valid = 1'b0;
        #1;
        chk("a_busy", bus.busy, 1'b1);
        chk("a_calc_din", bus.calc_din, D0);
        chk("a_ready_wait", bus.req0_ready, 1'b0);
        cyc(LAT - 1);
        chk("a_early_valid", bus.rsp_valid, 1'b0);
        cyc(1);
        chk("a_rsp_valid", bus.rsp_valid, 1'b1);
        chk("a_rsp_id", bus.rsp_id, 1'b0);
        chk("a_rsp_result", bus.rsp_result, 16'h01B8);
        chk("a_rsp_flags", {bus.rsp_neg, bus.rsp_err}, 2'b00);
        bus.rsp_ready = 1'b1;
        cyc(1);
        chk("a_done_valid", bus.rsp_valid, 1'b0);
        chk("a_done_busy", bus.busy, 1'b0);

        // Simultaneous requests right after reset: requester 0 wins the first tie.
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_din   = D1;
        bus.req1_valid = 1'b1;
        bus.req1_din   = D2;
        #1;
        chk("b_ready0", bus.req0_ready, 1'b1);
        chk("b_ready1", bus.req1_ready, 1'b0);
        cyc(1);
        bus.req0_valid = 1'b0;
        cyc(LAT - 1);
        chk("b_early_valid", bus.rsp_valid, 1'b0);
        cyc(1);
        chk("b_rsp0_valid", bus.rsp_valid, 1'b1);
        chk("b_rsp0_id", bus.rsp_id, 1'b0);
        chk("b_rsp0", {bus.rsp_neg, bus.rsp_result}, {1'b1, 16'h0065});
        cyc(1);
        chk("b_idle_valid", bus.rsp_valid, 1'b0);
        chk("b_ready1_next", bus.req1_ready, 1'b1);
        cyc(1);
        bus.req1_valid = 1'b0;
        chk("b_calc_din1", bus.calc_din, D2);
        cyc(LAT);
        chk("b_rsp1_valid", bus.rsp_valid, 1'b1);
        chk("b_rsp1_id", bus.rsp_id, 1'b1);
        chk("b_rsp1", {bus.rsp_neg, bus.rsp_result}, {1'b0, 16'h2E96});
        cyc(1);

        // Both held valid: grants alternate at LAT+2 spacing.
        bus.req0_valid = 1'b1;
        bus.req0_din   = D0;
        bus.req1_valid = 1'b1;
        bus.req1_din   = D2;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                gid[ng]  = bus.req1_ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            if (bus.rsp_valid)
                chk("c_rsp", {bus.rsp_neg, bus.rsp_result},
                    bus.rsp_id ? {1'b0, 16'h2E96} : {1'b0, 16'h01B8});
            @(posedge clk);
        end
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("c_grants", ng, 4);
        if (ng == 4) begin
            for (int i = 0; i < 4; i++) chk("c_gid", gid[i], i % 2);
            for (int i = 1; i < 4; i++) chk("c_spacing", gcyc[i] - gcyc[i-1], LAT + 2);
        end
        cyc(LAT + 1);
        chk("c_drained", bus.busy, 1'b0);

        // Illegal opcode: immediate error response, calc_din untouched.
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_din   = DI;
        #1;
        chk("d_ready1", bus.req1_ready, 1'b1);
        cyc(1);
        bus.req1_valid = 1'b0;
        chk("d_rsp_valid", bus.rsp_valid, 1'b1);
        chk("d_rsp_err", bus.rsp_err, 1'b1);
        chk("d_rsp_data", {bus.rsp_result, bus.rsp_neg}, 17'h0);
        chk("d_rsp_id", bus.rsp_id, 1'b1);
        chk("d_calc_din", bus.calc_din, D2);

        // Back-pressure in RESP: everything held, no new accept.
        bus.req0_valid = 1'b1;
        bus.req0_din   = D0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("e_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_neg,
                           bus.req0_ready, bus.req1_ready, bus.busy},
                {1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
            cyc(1);
        end
        bus.rsp_ready = 1'b1;
        cyc(1);
        chk("e_rsp_done", bus.rsp_valid, 1'b0);
        chk("e_ready0", bus.req0_ready, 1'b1);
        cyc(1);
        bus.req0_valid = 1'b0;
        chk("e_calc_din", bus.calc_din, D0);
        chk("e_busy", bus.busy, 1'b1);

        // Reset during WAIT aborts the operation with no response.
        cyc(1);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("f_busy", bus.busy, 1'b0);
        chk("f_rsp_valid", bus.rsp_valid, 1'b0);
        chk("f_calc_din", bus.calc_din, IDIN);
        for (int i = 0; i < LAT + 2; i++) begin
            cyc(1);
            chk("f_no_rsp", bus.rsp_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
